bcd_down_counter: RTL and testbench
===================================

Name: bcd_down_counter

Overview:
Cascadable multi-digit BCD down-counter with parallel load. It is the borrow-side counterpart of the team's BCD up-counter: decrement enable in (Bin), registered borrow pulse out (Bout). It serves as a countdown/timer digit chain, and chains to further stages via Bout -> Bin. It feeds 7-segment display decoders directly from q.

Parameters:
DIGITS, 2, number of BCD digits (1..8); q width = 4*DIGITS.
SATURATE, 0, 0 = wrap 00..0 -> 99..9 on underflow; 1 = hold at 00..0.

Ports:
Clk  input  1  system clock, all state on rising edge.
Rst_n  input  1  reset, synchronous, active-low.
Load  input  1  parallel load strobe; priority over Bin.
Din  input  4*DIGITS  load value, digit i at bits [4i+3:4i], digit 0 = least significant.
Bin  input  1  decrement enable / borrow in; one decrement per cycle when high.
Bout  output  1  registered borrow pulse, high one cycle after an underflow decrement.
q  output  4*DIGITS  current count, BCD per digit.
Zero  output  1  combinational, 1 when every digit of q is 0.

Behaviour:
- Reset: Rst_n sampled low at a Clk edge -> all digits 0, Bout 0. Zero then reads 1. Reset overrides Load and Bin, including mid-countdown. No asynchronous path.
- Priority per edge: Rst_n low > Load > Bin > hold.
- Load: cnt <= Din, with per-digit clamp: any digit > 9 loads as 9. Bout <= 0 on the load edge.
- Decrement (Bin=1, Load=0): digit 0 always steps. Digit i>0 steps only when digits 0..i-1 are all 0 (ripple borrow, evaluated combinationally within one cycle). A stepping digit at 0 becomes 9; otherwise it becomes d-1.
- Underflow occurs when Bin=1, Load=0 and cnt == all-zero:
  - SATURATE=0: cnt <= all 9s.
  - SATURATE=1: cnt stays all-zero.
  - Both modes: Bout <= 1 on that edge.
- Any other edge: Bout <= 0. Bout is therefore a single-cycle pulse per underflow. With Bin held high at zero under SATURATE=1, Bout stays high every cycle.
- Bin=0, Load=0: cnt holds, Bout <= 0.
- Latency: q reflects a decrement/load one cycle after the enabling edge. Zero tracks q with no added latency.
- Cascade: Bout of stage N drives Bin of stage N+1. The higher stage therefore decrements one cycle after the lower stage wraps, which matches the up-counter Cout timing.
- Non-BCD digits can only enter via Load and are clamped, so q never holds a digit > 9.

Decomposition:
- Shared package:
  - BCD_MAX = 4'd9.
  - BCD_ZERO = 4'd0.
  - BCD digit width constant = 4.
  - Clamp function (digit > 9 -> 9), also used by the up-counter load path.
- One sub-module: bcd_down_digit.
  - Inputs: Clk, Rst_n, Load, Din[3:0], Bin.
  - Outputs: q[3:0], Zero, Bnext = Bin & (q == 0).
  - Instantiated DIGITS times via generate. The top adds all-zero detection, SATURATE gating and the Bout register.

Test Plan:
- Reset mid-count, DIGITS=2: load 8'h37, Bin=1 for 3 cycles, then Rst_n=0 for 1 edge -> q=8'h34 before reset, q=8'h00, Zero=1, Bout=0 after; Load and Bin asserted during reset are ignored.
- Ripple borrow: load 8'h10, Bin=1 one cycle -> q=8'h09, Bout=0; load 8'h00, Bin=1 -> q=8'h99, Bout=1 for exactly one cycle, then 0.
- Full countdown SATURATE=0: load 8'h05, Bin held high 7 cycles -> q sequence 04,03,02,01,00,99,98; Bout high only in the cycle q=99.
- SATURATE=1: load 8'h01, Bin high 4 cycles -> q 00,00,00,00; Bout = 0,1,1,1.
- Load priority and clamp: Load=1 and Bin=1 same edge with Din=8'hA3 -> q=8'h93, Bout=0; the next Bin edge gives q=8'h92.
- Cascade two instances (DIGITS=1 each), low loaded 0, high loaded 2, Bin low=1 -> low goes to 9 with Bout pulse; the high stage reads 1 one cycle later; combined q=19 thereafter.

Source files
------------

// File: rtl/bcd_down_counter_pkg.sv
// Shared BCD constants and the load-path digit clamp.
package bcd_down_counter_pkg;

  localparam int         BCD_W    = 4;
  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  // Non-BCD codes (A..F) saturate to 9 so q never carries an illegal digit.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_down_counter_if.sv
// Load/decrement bus of the BCD down-counter; master drives, slave is the counter.
interface bcd_down_counter_if #(
  parameter int DIGITS = 2
) ();

  logic                  Load;
  logic [4*DIGITS-1:0]   Din;
  logic                  Bin;
  logic                  Bout;
  logic [4*DIGITS-1:0]   q;
  logic                  Zero;

  modport master (output Load, Din, Bin, input Bout, q, Zero);
  modport slave  (input Load, Din, Bin, output Bout, q, Zero);

endinterface

// File: rtl/bcd_down_digit.sv
// One BCD digit: clamped parallel load, decrement with 0 -> 9 wrap, borrow out.
module bcd_down_digit
  import bcd_down_counter_pkg::*;
(
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Load,
  input  logic [BCD_W-1:0] Din,
  input  logic             Bin,
  output logic [BCD_W-1:0] q,
  output logic             Zero,
  output logic             Bnext
);

  // Reset > load > decrement > hold.
  always_ff @(posedge Clk) begin
    if (!Rst_n)     q <= BCD_ZERO;
    else if (Load)  q <= bcd_clamp(Din);
    else if (Bin)   q <= (q == BCD_ZERO) ? BCD_MAX : q - 4'd1;
  end

  assign Zero  = (q == BCD_ZERO);
  // Next digit steps only when this one steps from 0.
  assign Bnext = Bin & Zero;

endmodule

// File: rtl/bcd_down_counter.sv
// Cascadable multi-digit BCD down-counter with parallel load and registered borrow out.
module bcd_down_counter
  import bcd_down_counter_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter bit SATURATE = 1'b0
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  bcd_down_counter_if.slave      bus
);

  logic [DIGITS-1:0][BCD_W-1:0] digit_q;
  logic [DIGITS-1:0]            digit_zero;
  logic [DIGITS:0]              borrow;
  logic                         all_zero;
  logic                         underflow;
  logic                         bout_r;
  logic                         unused_borrow;

  assign all_zero  = &digit_zero;
  assign underflow = bus.Bin & all_zero;

  // In saturate mode the chain is frozen at all-zero so nothing wraps to 9.
  assign borrow[0] = bus.Bin & ~(SATURATE & all_zero);

  // Borrow ripples through the digit chain within one cycle.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_down_digit u_digit (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .Load  (bus.Load),
      .Din   (bus.Din[BCD_W*i +: BCD_W]),
      .Bin   (borrow[i]),
      .q     (digit_q[i]),
      .Zero  (digit_zero[i]),
      .Bnext (borrow[i+1])
    );
  end

  // Top-digit borrow duplicates the underflow term; Bout uses the saturate-independent one.
  assign unused_borrow = borrow[DIGITS];

  // One-cycle borrow pulse per underflow decrement; load clears it.
  always_ff @(posedge Clk) begin
    if (!Rst_n)         bout_r <= 1'b0;
    else if (bus.Load)  bout_r <= 1'b0;
    else                bout_r <= underflow;
  end

  assign bus.Bout = bout_r;
  assign bus.q    = digit_q;
  assign bus.Zero = all_zero;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed bench: wrap and saturate counters plus a two-stage single-digit cascade.
module tb_bcd_down_counter;

  logic Clk;
  logic Rst_n;
  int   checks;
  int   errors;

  bcd_down_counter_if #(.DIGITS(2)) w_bus ();
  bcd_down_counter_if #(.DIGITS(2)) s_bus ();
  bcd_down_counter_if #(.DIGITS(1)) lo_bus ();
  bcd_down_counter_if #(.DIGITS(1)) hi_bus ();

  bcd_down_counter #(.DIGITS(2), .SATURATE(1'b0)) dut_wrap (.Clk(Clk), .Rst_n(Rst_n), .bus(w_bus));
  bcd_down_counter #(.DIGITS(2), .SATURATE(1'b1)) dut_sat  (.Clk(Clk), .Rst_n(Rst_n), .bus(s_bus));
  bcd_down_counter #(.DIGITS(1), .SATURATE(1'b0)) dut_lo   (.Clk(Clk), .Rst_n(Rst_n), .bus(lo_bus));
  bcd_down_counter #(.DIGITS(1), .SATURATE(1'b0)) dut_hi   (.Clk(Clk), .Rst_n(Rst_n), .bus(hi_bus));

  assign hi_bus.Bin = lo_bus.Bout;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    w_bus.Load = 1'b1; w_bus.Din = 8'h55; w_bus.Bin = 1'b1;
    s_bus.Load = 1'b0; s_bus.Din = 8'h00; s_bus.Bin = 1'b0;
    lo_bus.Load = 1'b0; lo_bus.Din = 4'h0; lo_bus.Bin = 1'b0;
    hi_bus.Load = 1'b0; hi_bus.Din = 4'h0;
    tick();
    checks++;
    if (w_bus.q !== 8'h00 || w_bus.Zero !== 1'b1 || w_bus.Bout !== 1'b0) begin
      errors++; $display("FAIL reset_init: q=%h zero=%b bout=%b want 00/1/0", w_bus.q, w_bus.Zero, w_bus.Bout);
    end
    Rst_n = 1'b1;
    w_bus.Load = 1'b1; w_bus.Din = 8'h37; w_bus.Bin = 1'b0;
    tick();
    w_bus.Load = 1'b0; w_bus.Bin = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (w_bus.q !== 8'h34 || w_bus.Zero !== 1'b0) begin
      errors++; $display("FAIL reset_precount: q=%h zero=%b want 34/0", w_bus.q, w_bus.Zero);
    end
    Rst_n = 1'b0; w_bus.Load = 1'b1; w_bus.Din = 8'h77; w_bus.Bin = 1'b1;
    tick();
    checks++;
    if (w_bus.q !== 8'h00 || w_bus.Zero !== 1'b1 || w_bus.Bout !== 1'b0) begin
      errors++; $display("FAIL reset_midcount: q=%h zero=%b bout=%b want 00/1/0", w_bus.q, w_bus.Zero, w_bus.Bout);
    end
    Rst_n = 1'b1; w_bus.Load = 1'b0; w_bus.Bin = 1'b0;
  endtask

  task automatic test_ripple();
    w_bus.Load = 1'b1; w_bus.Din = 8'h10; w_bus.Bin = 1'b0;
    tick();
    w_bus.Load = 1'b0; w_bus.Bin = 1'b1;
    tick();
    checks++;
    if (w_bus.q !== 8'h09 || w_bus.Bout !== 1'b0) begin
      errors++; $display("FAIL ripple_10: q=%h bout=%b want 09/0", w_bus.q, w_bus.Bout);
    end
    w_bus.Load = 1'b1; w_bus.Din = 8'h00; w_bus.Bin = 1'b0;
    tick();
    w_bus.Load = 1'b0; w_bus.Bin = 1'b1;
    tick();
    checks++;
    if (w_bus.q !== 8'h99 || w_bus.Bout !== 1'b1 || w_bus.Zero !== 1'b0) begin
      errors++; $display("FAIL ripple_wrap: q=%h bout=%b zero=%b want 99/1/0", w_bus.q, w_bus.Bout, w_bus.Zero);
    end
    w_bus.Bin = 1'b0;
    tick();
    checks++;
    if (w_bus.q !== 8'h99 || w_bus.Bout !== 1'b0) begin
      errors++; $display("FAIL ripple_hold: q=%h bout=%b want 99/0", w_bus.q, w_bus.Bout);
    end
  endtask

  task automatic test_countdown();
    logic [7:0] exp_q [7];
    logic       exp_b [7];
    exp_q = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h99, 8'h98};
    exp_b = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    w_bus.Load = 1'b1; w_bus.Din = 8'h05; w_bus.Bin = 1'b0;
    tick();
    w_bus.Load = 1'b0; w_bus.Bin = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      checks++;
      if (w_bus.q !== exp_q[k] || w_bus.Bout !== exp_b[k] || w_bus.Zero !== (exp_q[k] == 8'h00)) begin
        errors++; $display("FAIL countdown[%0d]: q=%h bout=%b zero=%b want %h/%b", k, w_bus.q, w_bus.Bout, w_bus.Zero, exp_q[k], exp_b[k]);
      end
    end
    w_bus.Bin = 1'b0;
  endtask

  task automatic test_saturate();
    logic exp_b [4];
    exp_b = '{1'b0, 1'b1, 1'b1, 1'b1};
    s_bus.Load = 1'b1; s_bus.Din = 8'h01; s_bus.Bin = 1'b0;
    tick();
    s_bus.Load = 1'b0; s_bus.Bin = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (s_bus.q !== 8'h00 || s_bus.Bout !== exp_b[k] || s_bus.Zero !== 1'b1) begin
        errors++; $display("FAIL saturate[%0d]: q=%h bout=%b zero=%b want 00/%b/1", k, s_bus.q, s_bus.Bout, s_bus.Zero, exp_b[k]);
      end
    end
    s_bus.Bin = 1'b0;
    tick();
    checks++;
    if (s_bus.q !== 8'h00 || s_bus.Bout !== 1'b0) begin
      errors++; $display("FAIL saturate_release: q=%h bout=%b want 00/0", s_bus.q, s_bus.Bout);
    end
  endtask

  task automatic test_load_clamp();
    w_bus.Load = 1'b1; w_bus.Din = 8'hA3; w_bus.Bin = 1'b1;
    tick();
    checks++;
    if (w_bus.q !== 8'h93 || w_bus.Bout !== 1'b0) begin
      errors++; $display("FAIL load_priority: q=%h bout=%b want 93/0", w_bus.q, w_bus.Bout);
    end
    w_bus.Load = 1'b0;
    tick();
    checks++;
    if (w_bus.q !== 8'h92) begin
      errors++; $display("FAIL load_then_dec: q=%h want 92", w_bus.q);
    end
    w_bus.Load = 1'b1; w_bus.Din = 8'hFC; w_bus.Bin = 1'b0;
    tick();
    checks++;
    if (w_bus.q !== 8'h99) begin
      errors++; $display("FAIL clamp_both: q=%h want 99", w_bus.q);
    end
    // Load on the edge that would otherwise underflow must suppress Bout.
    w_bus.Din = 8'h00;
    tick();
    w_bus.Din = 8'h42; w_bus.Bin = 1'b1;
    tick();
    checks++;
    if (w_bus.q !== 8'h42 || w_bus.Bout !== 1'b0) begin
      errors++; $display("FAIL load_over_underflow: q=%h bout=%b want 42/0", w_bus.q, w_bus.Bout);
    end
    w_bus.Load = 1'b0; w_bus.Bin = 1'b0;
  endtask

  task automatic test_cascade();
    lo_bus.Load = 1'b1; lo_bus.Din = 4'h0; lo_bus.Bin = 1'b0;
    hi_bus.Load = 1'b1; hi_bus.Din = 4'h2;
    tick();
    lo_bus.Load = 1'b0; hi_bus.Load = 1'b0; lo_bus.Bin = 1'b1;
    tick();
    checks++;
    if (lo_bus.q !== 4'h9 || lo_bus.Bout !== 1'b1 || hi_bus.q !== 4'h2) begin
      errors++; $display("FAIL cascade_wrap: lo=%h bout=%b hi=%h want 9/1/2", lo_bus.q, lo_bus.Bout, hi_bus.q);
    end
    lo_bus.Bin = 1'b0;
    tick();
    checks++;
    if ({hi_bus.q, lo_bus.q} !== 8'h19 || lo_bus.Bout !== 1'b0) begin
      errors++; $display("FAIL cascade_follow: q=%h bout=%b want 19/0", {hi_bus.q, lo_bus.q}, lo_bus.Bout);
    end
    tick();
    checks++;
    if ({hi_bus.q, lo_bus.q} !== 8'h19 || hi_bus.Bout !== 1'b0) begin
      errors++; $display("FAIL cascade_hold: q=%h hi_bout=%b want 19/0", {hi_bus.q, lo_bus.q}, hi_bus.Bout);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_ripple();
    test_countdown();
    test_saturate();
    test_load_clamp();
    test_cascade();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
